mcp_stack_ctrl: RTL and testbench

- Controller for the processor's hardware operand stack.
- Owns the stack pointer and sequences an external single-port, synchronous-read stack RAM.
- Services push/pop/tos requests from the multicycle controller with a busy/done handshake.
- Reports full, empty, overflow and underflow.

---
 rtl/mcp_stack_ctrl.sv | 143 ++++++++++++++
 tb/tb_mcp_stack_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcp_stack_ctrl.sv
// rtl/mcp_stack_ctrl.sv - operand stack controller sequencing a synchronous-read stack RAM
module mcp_stack_ctrl #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  tos,
  input  logic [DATA_W-1:0]     d_in,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     d_out,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf_err,
  output logic                  unf_err,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** DEPTH_LOG2);
  localparam logic [CW-1:0] SP_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_CAPTURE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         sp_q, sp_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [CW-1:0]         sp_m1;

  // sp_m1 is the index of the current top word when the stack is non-empty
  assign sp_m1 = sp_q - SP_ONE;

  // Next-state logic: request arbitration in IDLE, then the RAM access sequence
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    // clear first so that an error raised this cycle still sets its flag
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (sp_q == '0) begin
            unf_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            addr_d  = sp_m1[DEPTH_LOG2-1:0];
            sp_d    = sp_m1;
            state_d = S_READ;
          end
        end else if (push) begin
          if (sp_q == DEPTH_C) begin
            ovf_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            addr_d  = sp_q[DEPTH_LOG2-1:0];
            wdata_d = d_in;
            sp_d    = sp_q + SP_ONE;
            state_d = S_WRITE;
          end
        end else if (tos) begin
          if (sp_q == '0) begin
            unf_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            addr_d  = sp_m1[DEPTH_LOG2-1:0];
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        dout_d  = ram_rdata;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign d_out     = dout_q;
  assign count     = sp_q;
  assign full      = (sp_q == DEPTH_C);
  assign empty     = (sp_q == '0);
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
  assign ram_we    = (state_q == S_WRITE);
  assign ram_addr  = (state_q == S_WRITE || state_q == S_READ) ? addr_q : '0;
  assign ram_wdata = (state_q == S_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_mcp_stack_ctrl.sv
// tb/tb_mcp_stack_ctrl.sv - self-checking bench for mcp_stack_ctrl against a stack-level model
module tb_mcp_stack_ctrl;

  localparam int DW = 8;
  localparam int AL = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0, pop = 1'b0, tos = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] d_in = '0;
  logic          busy, done, full, empty, ovf_err, unf_err, ram_we;
  logic [DW-1:0] d_out, ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [AL:0]   count;
  logic [AL-1:0] ram_addr;

  int checks = 0;
  int errors = 0;

  mcp_stack_ctrl #(.DATA_W(DW), .DEPTH_LOG2(AL)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .d_in(d_in),
    .err_clr(err_clr), .busy(busy), .done(done), .d_out(d_out), .count(count),
    .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // External single-port RAM with one-cycle read latency
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle", nm, act, act, exp, exp);
    end
  endtask

  // Stack-level model: a queue of words plus the cycle at which each visible effect is due
  int      cyc = 0;
  int      stk[$];
  int      d_out_m = 0, ovf_m = 0, unf_m = 0;
  int      done_at = -1, we_at = -1, rd_at = -1, dout_at = -1, busy_last = -1;
  int      we_addr = 0, we_data = 0, rd_addr = 0, dout_val = 0;

  always @(posedge clk) begin
    int c;
    c = cyc;
    if (rst) begin
      stk.delete();
      d_out_m = 0; ovf_m = 0; unf_m = 0;
      done_at = -1; we_at = -1; rd_at = -1; dout_at = -1; busy_last = -1;
    end else begin
      if (err_clr) begin ovf_m = 0; unf_m = 0; end
      if (c > busy_last) begin
        if (pop || (!push && tos)) begin
          if (stk.size() == 0) begin
            unf_m = 1;
            done_at = c + 1;
          end else begin
            rd_addr = stk.size() - 1;
            dout_val = stk[$];
            if (pop) void'(stk.pop_back());
            rd_at = c + 1; dout_at = c + 3; done_at = c + 3; busy_last = c + 2;
          end
        end else if (push) begin
          if (stk.size() == DEPTH) begin
            ovf_m = 1;
            done_at = c + 1;
          end else begin
            we_addr = stk.size(); we_data = int'(d_in);
            stk.push_back(int'(d_in));
            we_at = c + 1; done_at = c + 2; busy_last = c + 1;
          end
        end
      end
    end
    cyc = cyc + 1;
    if (cyc == dout_at) d_out_m = dout_val;
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", int'(busy), int'(cyc <= busy_last));
      chk("done", int'(done), int'(cyc == done_at));
      chk("count", int'(count), stk.size());
      chk("full", int'(full), int'(stk.size() == DEPTH));
      chk("empty", int'(empty), int'(stk.size() == 0));
      chk("ovf_err", int'(ovf_err), ovf_m);
      chk("unf_err", int'(unf_err), unf_m);
      chk("d_out", int'(d_out), d_out_m);
      chk("ram_we", int'(ram_we), int'(cyc == we_at));
      chk("ram_wdata", int'(ram_wdata), (cyc == we_at) ? we_data : 0);
      chk("ram_addr", int'(ram_addr), (cyc == we_at) ? we_addr : ((cyc == rd_at) ? rd_addr : 0));
    end
  end

  // Drive one request for a single cycle and return the cycles until done
  task automatic do_op(input logic p_push, input logic p_pop, input logic p_tos,
                       input logic [DW-1:0] din, input logic clr, output int lat);
    push = p_push; pop = p_pop; tos = p_tos; d_in = din; err_clr = clr;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int lat;
  byte unsigned vals[3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_dout", int'(d_out), 0);

    // push three, pop three in LIFO order
    foreach (vals[i]) begin
      do_op(1'b1, 1'b0, 1'b0, vals[i], 1'b0, lat);
      chk("push_lat", lat, 2);
    end
    chk("count3", int'(count), 3);
    for (int i = 2; i >= 0; i--) begin
      do_op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, lat);
      chk("pop_lat", lat, 3);
      chk("pop_val", int'(d_out), int'(vals[i]));
    end
    chk("empty_after", int'(empty), 1);

    // fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 1'b0, 8'(i * 3 + 1), 1'b0, lat);
    chk("full16", int'(full), 1);
    do_op(1'b1, 1'b0, 1'b0, 8'hEE, 1'b0, lat);
    chk("ovf_lat", lat, 1);
    chk("ovf_set", int'(ovf_err), 1);
    chk("ovf_count", int'(count), 16);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    chk("ovf_clr", int'(ovf_err), 0);
    do_op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, lat);
    chk("tos_full", int'(d_out), 46);

    // underflow from empty
    do_reset();
    do_op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, lat);
    chk("unf_lat_pop", lat, 1);
    chk("unf_set", int'(unf_err), 1);
    do_op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, lat);
    chk("unf_lat_tos", lat, 1);
    chk("unf_dout", int'(d_out), 0);
    do_op(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, lat);
    chk("unf_set_wins", int'(unf_err), 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    chk("unf_clr", int'(unf_err), 0);
    do_op(1'b1, 1'b1, 1'b0, 8'h66, 1'b0, lat);
    chk("unf_only", int'(ovf_err) * 2 + int'(unf_err), 1);
    chk("unf_no_push", int'(count), 0);

    // tos does not remove
    do_op(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, lat);
    do_op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, lat);
    chk("tos1", int'(d_out), 8'h5A);
    do_op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, lat);
    chk("tos2", int'(d_out), 8'h5A);
    chk("tos_count", int'(count), 1);
    do_op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, lat);
    chk("pop5a", int'(d_out), 8'h5A);
    chk("pop5a_count", int'(count), 0);

    // pop beats push; push while busy is ignored
    do_op(1'b1, 1'b0, 1'b0, 8'h01, 1'b0, lat);
    do_op(1'b1, 1'b0, 1'b0, 8'h02, 1'b0, lat);
    do_op(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, lat);
    chk("prio_lat", lat, 3);
    chk("prio_val", int'(d_out), 8'h02);
    chk("prio_count", int'(count), 1);
    pop = 1'b1; @(negedge clk);
    pop = 1'b0; push = 1'b1; d_in = 8'h99; @(negedge clk);
    push = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("busy_ignore_count", int'(count), 0);
    chk("busy_ignore_dout", int'(d_out), 8'h01);

    // reset in the middle of a pop
    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i), 1'b0, lat);
    pop = 1'b1; @(negedge clk);
    pop = 1'b0; rst = 1'b1; @(negedge clk);
    rst = 1'b0;
    chk("midrst_count", int'(count), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_dout", int'(d_out), 0);
    for (int i = 0; i < 5; i++) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
